// File: rtl/gat_feat_streamer_pkg.sv
// gat_pkg: FSM state encoding and derived-size helpers for the feature streamer.
package gat_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int feat_depth(input int subgraphs, input int feats);
    return subgraphs * feats;
  endfunction
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/gat_feat_streamer_if.sv
// gat_feat_streamer_if: AXI-Stream feature channel with tuser marking node ends.
interface gat_feat_streamer_if #(parameter int W = 32);
  logic [W-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tuser;
  logic tlast;
  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/gat_feat_streamer_fifo.sv
// gat_sync_fifo: show-ahead synchronous FIFO absorbing BRAM returns behind the stream.
module gat_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic empty,
  output logic [CW-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? nxt(wp) : wp;
      rp <= pop ? nxt(rp) : rp;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  assign dout = mem[rp];
  assign empty = count == '0;
endmodule

// File: rtl/gat_feat_streamer.sv
// gat_feat_streamer: streams one frame of node features from BRAM onto AXI-Stream.
module gat_feat_streamer
  import gat_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NUM_SUBGRAPHS = 2708,
  parameter int NUM_FEATURE_OUT = 16,
  parameter int BRAM_RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int NEW_FEATURE_DEPTH = feat_depth(NUM_SUBGRAPHS, NUM_FEATURE_OUT),
  localparam int NEW_FEATURE_ADDR_W = addr_w(NEW_FEATURE_DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic gat_ready,
  input  logic start,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0] feat_bram_dout,
  gat_feat_streamer_if.master m_axis,
  output logic busy,
  output logic done
);
  localparam int AW = NEW_FEATURE_ADDR_W;
  localparam int FW = addr_w(NUM_FEATURE_OUT);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int L = BRAM_RD_LATENCY;
  state_t state, state_n;
  logic [AW-1:0] widx, addr_q;
  logic [FW-1:0] fidx;
  logic [L:0] vpipe;
  logic [1:0] fpipe [0:L];
  logic [NEW_FEATURE_WIDTH+1:0] head;
  logic [CW-1:0] occ;
  logic issue, last_idx, last_feat, pop, fifo_empty;
  int total;
  // total counts every word already issued but not yet handed downstream
  always_comb begin
    last_idx = widx == AW'(NEW_FEATURE_DEPTH - 1);
    last_feat = fidx == FW'(NUM_FEATURE_OUT - 1);
    pop = m_axis.tvalid & m_axis.tready;
    total = $countones(vpipe) + int'(occ) - int'(pop);
    issue = (state == IDLE && start && gat_ready) || (state == RUN && total < FIFO_DEPTH);
    state_n = state;
    case (state)
      IDLE: state_n = issue ? (last_idx ? DRAIN : RUN) : IDLE;
      RUN: state_n = issue && last_idx ? DRAIN : RUN;
      DRAIN: state_n = vpipe == '0 && occ == CW'(pop) ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      widx <= '0;
      fidx <= '0;
      addr_q <= '0;
      vpipe <= '0;
    end else begin
      state <= state_n;
      vpipe <= {vpipe[L-1:0], issue};
      addr_q <= issue ? widx : addr_q;
      widx <= state == DONE ? '0 : issue && !last_idx ? widx + AW'(1) : widx;
      fidx <= state == DONE ? '0 : issue ? (last_feat ? '0 : fidx + FW'(1)) : fidx;
    end
  end
  // node/frame markers ride alongside the read so they meet the returning data
  always_ff @(posedge clk) begin
    fpipe[0] <= {last_idx, last_feat};
    for (int i = 1; i <= L; i++) fpipe[i] <= fpipe[i-1];
  end
  gat_sync_fifo #(.WIDTH(NEW_FEATURE_WIDTH + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(vpipe[L]),
    .din({fpipe[L], feat_bram_dout}),
    .pop(pop),
    .dout(head),
    .empty(fifo_empty),
    .count(occ)
  );
  assign m_axis.tvalid = !fifo_empty;
  assign {m_axis.tlast, m_axis.tuser, m_axis.tdata} = fifo_empty ? '0 : head;
  assign feat_bram_addrb = {addr_q, 2'b00};
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_gat_feat_streamer.sv
// tb_gat_feat_streamer: scoreboard bench for the feature streamer on a 3x4 frame.
module tb_gat_feat_streamer;
  localparam int NS = 3;
  localparam int NF = 4;
  localparam int N = NS * NF;
  logic clk = 0;
  logic rst, gat_ready, start, busy, done;
  logic [5:0] addrb;
  logic [31:0] dout, p1;
  gat_feat_streamer_if #(.W(32)) m_axis ();
  gat_feat_streamer #(.NUM_SUBGRAPHS(NS), .NUM_FEATURE_OUT(NF)) dut (
    .clk(clk), .rst(rst), .gat_ready(gat_ready), .start(start),
    .feat_bram_addrb(addrb), .feat_bram_dout(dout), .m_axis(m_axis),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    p1 <= 32'h100 + 32'(addrb[5:2]);
    dout <= p1;
  end
  int checks = 0, errors = 0, cyc = 0;
  int beats, first_cyc, last_cyc, done_cyc, done_cnt, saw_tlast, max_out, t0;
  logic stall_prev = 0;
  logic [33:0] prev_word;
  logic [33:0] exp_q [$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear_frame();
    beats = 0; first_cyc = 0; last_cyc = 0; done_cyc = 0; done_cnt = 0; saw_tlast = 0; max_out = 0;
  endtask
  task automatic push_frame();
    for (int i = 0; i < N; i++) exp_q.push_back({i == N - 1, i % NF == NF - 1, 32'h100 + 32'(i)});
  endtask
  always @(negedge clk) begin
    logic [33:0] e;
    int o;
    if (busy) begin
      o = int'(addrb[5:2]) + 1 - beats;
      if (o > max_out) max_out = o;
    end
    if (stall_prev) chk("stall_hold", {m_axis.tvalid, m_axis.tlast, m_axis.tuser, m_axis.tdata}, {1'b1, prev_word});
    stall_prev = m_axis.tvalid && !m_axis.tready && !rst;
    prev_word = {m_axis.tlast, m_axis.tuser, m_axis.tdata};
    if (m_axis.tvalid && m_axis.tready) begin
      if (exp_q.size() == 0) chk("sb_empty", 64'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("beat", {m_axis.tlast, m_axis.tuser, m_axis.tdata}, e);
      end
      if (beats == 0) first_cyc = cyc;
      last_cyc = cyc;
      beats++;
      if (m_axis.tlast) saw_tlast++;
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end
  // mode: 0 ready, 1 toggle, 2 stall 20 cycles, 3 hold final beat 3 cycles
  task automatic run_frame(input int mode, input logic dup_start);
    int hold = 0;
    clear_frame();
    start = 1;
    t0 = cyc;
    push_frame();
    step(1);
    start = 0;
    for (int n = 0; n < 400 && done_cnt == 0; n++) begin
      start = dup_start && n == 5;
      case (mode)
        0: m_axis.tready = 1;
        1: m_axis.tready = n % 2 == 0;
        2: m_axis.tready = n >= 20;
        default: begin
          m_axis.tready = !(m_axis.tvalid && m_axis.tlast && hold < 3);
          if (!m_axis.tready) hold++;
        end
      endcase
      if (mode == 2 && n == 19) chk("stall_addr", 64'(addrb[5:2]), 3);
      step(1);
    end
    start = 0;
    if (done_cnt == 0) chk("timeout", 64'(done_cnt), 1);
    step(3);
    chk("beats", 64'(beats), N);
    chk("tlast_cnt", 64'(saw_tlast), 1);
    chk("done_lag", 64'(done_cyc - last_cyc), 1);
    chk("done_cnt", 64'(done_cnt), 1);
    chk("idle_busy", 64'(busy), 0);
    chk("sb_left", 64'(exp_q.size()), 0);
    if (mode == 3) chk("hold_cycles", 64'(hold), 3);
  endtask
  initial begin
    rst = 1; gat_ready = 1; start = 0; m_axis.tready = 0;
    clear_frame();
    step(3);
    chk("rst_outs", {addrb, m_axis.tvalid, m_axis.tuser, m_axis.tlast, busy, done}, 0);
    chk("rst_tdata", 64'(m_axis.tdata), 0);
    rst = 0;
    step(1);
    run_frame(0, 0);
    chk("first_lat", 64'(first_cyc - t0), 4);
    chk("burst_len", 64'(last_cyc - first_cyc), N - 1);
    run_frame(1, 0);
    run_frame(2, 0);
    chk("max_out", 64'(max_out), 4);
    gat_ready = 0;
    start = 1;
    step(1);
    start = 0;
    step(3);
    chk("noready_busy", 64'(busy), 0);
    chk("noready_tvalid", 64'(m_axis.tvalid), 0);
    gat_ready = 1;
    run_frame(0, 1);
    clear_frame();
    m_axis.tready = 1;
    start = 1;
    push_frame();
    step(1);
    start = 0;
    for (int n = 0; n < 100 && beats < 5; n++) step(1);
    if (beats < 5) chk("timeout_beat5", 64'(beats), 5);
    rst = 1;
    step(1);
    chk("mid_rst_outs", {addrb, m_axis.tvalid, m_axis.tuser, m_axis.tlast, busy, done}, 0);
    chk("mid_rst_tdata", 64'(m_axis.tdata), 0);
    exp_q.delete();
    rst = 0;
    step(5);
    chk("mid_rst_tlast", 64'(saw_tlast), 0);
    chk("mid_rst_quiet", 64'(m_axis.tvalid), 0);
    run_frame(0, 0);
    run_frame(3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gat_feat_streamer.md
GAT_FEAT_STREAMER -- requirements
Module: gat_feat_streamer

Interface
REQ-001 Parameter NEW_FEATURE_WIDTH, default 32: width of one feature word.
REQ-002 Parameter NUM_SUBGRAPHS, default 2708: nodes per frame.
REQ-003 Parameter NUM_FEATURE_OUT, default 16: features per node.
REQ-004 Parameter BRAM_RD_LATENCY, default 2: feat BRAM addrb-to-dout latency, cycles.
REQ-005 Parameter FIFO_DEPTH, default 4: output skid FIFO entries; SHALL be >= BRAM_RD_LATENCY+2.
REQ-006 Derived: NEW_FEATURE_DEPTH = NUM_SUBGRAPHS*NUM_FEATURE_OUT; NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH).
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 gat_ready  in  1  accelerator result-valid flag.
REQ-010 start  in  1  one-cycle request to stream one frame.
REQ-011 feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  byte address = {word_idx, 2'b00}.
REQ-012 feat_bram_dout  in  NEW_FEATURE_WIDTH  read data, valid BRAM_RD_LATENCY cycles after address.
REQ-013 m_axis_tdata  out  NEW_FEATURE_WIDTH  feature word.
REQ-014 m_axis_tvalid / m_axis_tready  out / in  1  AXI-Stream handshake.
REQ-015 m_axis_tuser  out  1  high on the last feature of each node.
REQ-016 m_axis_tlast  out  1  high on the last word of the frame.
REQ-017 busy  out  1  high in any state other than IDLE; done  out  1  one-cycle pulse at frame end.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE->RUN only when start=1 and gat_ready=1; start is ignored in all other cases, including any state other than IDLE.
REQ-020 RUN issues word indices 0..NEW_FEATURE_DEPTH-1 in order, at most one per cycle, via registered feat_bram_addrb.
REQ-021 An index issues only when (in-flight reads + FIFO occupancy) < FIFO_DEPTH; a pop in the same cycle counts as freeing a slot.
REQ-022 In-flight reads are tracked by a BRAM_RD_LATENCY-deep valid shift register; dout is pushed into the FIFO when the tap reaches the end.
REQ-023 RUN->DRAIN in the cycle after index NEW_FEATURE_DEPTH-1 issues; feat_bram_addrb then holds its last value.
REQ-024 DRAIN->DONE when no reads are in flight, the FIFO is empty, and the final beat has been accepted; DONE lasts 1 cycle (done=1), then goes to IDLE.
REQ-025 Latency: start accepted in cycle 0, addrb=0 in cycle 1, first tvalid in cycle 2+BRAM_RD_LATENCY.
REQ-026 With tready held high: one beat per cycle, no bubbles.
REQ-027 tdata/tuser/tlast are stable while tvalid=1 and tready=0; tvalid does not drop until the beat is accepted.
REQ-028 tuser=1 when the word's feature index = NUM_FEATURE_OUT-1; tlast=1 only on word NEW_FEATURE_DEPTH-1.
REQ-029 Word and feature counters are sized by $clog2; there is no wrap within a frame; counters clear on IDLE entry.
REQ-030 gat_ready falling mid-frame has no effect; the frame completes.

Reset
REQ-031 On rst: state=IDLE, feat_bram_addrb=0, m_axis_tvalid=0, tdata=0, tuser=0, tlast=0, busy=0, done=0.
REQ-032 On rst: FIFO is flushed and the in-flight valid pipe is cleared; data returning after reset is discarded.
REQ-033 Reset mid-frame aborts the frame with no tlast emitted; the next start restarts at index 0.

Structure
REQ-034 gat_pkg holds the FSM state enum and the derived-width localparam functions shared with gat_top.
REQ-035 The skid FIFO is a sub-module, gat_sync_fifo (parameters WIDTH, DEPTH), carrying {tlast, tuser, tdata}.

Verification (NUM_SUBGRAPHS=3, NUM_FEATURE_OUT=4, BRAM model: dout = addr index + 0x100)
REQ-036 Reset, gat_ready=1, start pulse, tready=1 -> 12 beats 0x100..0x10B on consecutive cycles; first tvalid in cycle 4; tuser on beats 3/7/11; tlast on beat 11; done 1 cycle later.
REQ-037 tready toggling 1-0 every cycle -> same data order, no loss or duplicates, outputs stable during stalls.
REQ-038 tready=0 for 20 cycles after start -> in-flight+occupancy never exceeds 4, addrb stalls, no overflow; on release, 12 correct beats.
REQ-039 start with gat_ready=0 -> stays IDLE, busy=0; start while busy -> ignored, still exactly 12 beats.
REQ-040 rst at beat 5 -> outputs at reset values next cycle, no tlast; a new start streams 0x100.. from index 0.
REQ-041 Final beat held with tready=0 for 3 cycles -> done asserts only after the handshake completes.
